// File: rtl/dmem_store_buffer.sv
// Posted-store buffer between the memory stage and the single-port data memory.
// Optional build macro STORE_BUF_COALESCE_EN merges a store into an existing entry with the same word address.
module dmem_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_data_w,
  input  logic                    cpu_we,
  input  logic                    cpu_re,
  output logic [31:0]             cpu_data_r,
  input  logic                    flush_req,
  output logic                    cpu_stall,
  output logic [31:0]             dmem_addr,
  output logic [31:0]             dmem_data_w,
  output logic                    dmem_mem_rw,
  input  logic [31:0]             dmem_data_r,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

`ifdef STORE_BUF_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             drain;
  logic             store_ok;
  logic             coal;
  logic             push;
  logic             fwd_hit;
  logic [PTR_W-1:0] fwd_idx;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign occupancy = count;

  // Flush handshake: flush_req is a level held by the CPU; cpu_stall stays high
  // until the last queued store is on the port, and drops in the cycle empty rises.
  assign cpu_stall = flush_req && !empty;

  // A load owns the memory port unless a flush is pending.
  assign drain = !empty && !rst && (!cpu_re || flush_req);

  assign dmem_addr   = drain ? addr_q[head] : cpu_addr;
  assign dmem_data_w = data_q[head];
  assign dmem_mem_rw = drain;

  // Walk from oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) &&
          (addr_q[head + PTR_W'(i)][ADDR_W-1:0] == cpu_addr[ADDR_W-1:0])) begin
        fwd_hit = 1'b1;
        fwd_idx = head + PTR_W'(i);
      end
    end
  end

  assign cpu_data_r = fwd_hit ? data_q[fwd_idx] : dmem_data_r;

  assign store_ok = cpu_we && !cpu_stall;
  // The head leaving this cycle cannot absorb a store, so that case appends.
  assign coal     = COALESCE && store_ok && fwd_hit && !(drain && (fwd_idx == head));
  // Push only when a slot exists; a full buffer frees one by draining in the same cycle.
  assign push     = store_ok && !coal && (!full || drain);

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        addr_q[tail] <= cpu_addr;
        data_q[tail] <= cpu_data_w;
        tail         <= tail + 1'b1;
      end
      if (coal) begin
        addr_q[fwd_idx] <= cpu_addr;
        data_q[fwd_idx] <= cpu_data_w;
      end
      if (drain) begin
        head <= head + 1'b1;
      end
      if (push && !drain) begin
        count <= count + 1'b1;
      end else if (!push && drain) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer: memory model written on negedge, expected-write
// queue checked at every memory write, and hand-computed checks of the CPU-facing outputs.
module tb_dmem_store_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_data_w;
  logic        cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_data_r;
  logic        flush_req;
  logic        cpu_stall;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_data_w;
  logic        dmem_mem_rw;
  logic [31:0] dmem_data_r;
  logic [2:0]  occupancy;
  logic        full;
  logic        empty;

  logic [31:0] mem [1024];
  logic [63:0] exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  dmem_store_buffer #(.DEPTH(4), .ADDR_W(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_addr    (cpu_addr),
    .cpu_data_w  (cpu_data_w),
    .cpu_we      (cpu_we),
    .cpu_re      (cpu_re),
    .cpu_data_r  (cpu_data_r),
    .flush_req   (flush_req),
    .cpu_stall   (cpu_stall),
    .dmem_addr   (dmem_addr),
    .dmem_data_w (dmem_data_w),
    .dmem_mem_rw (dmem_mem_rw),
    .dmem_data_r (dmem_data_r),
    .occupancy   (occupancy),
    .full        (full),
    .empty       (empty)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  assign dmem_data_r = mem[dmem_addr[9:0]];

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard: every memory write must be the next expected one ----------------
  always @(negedge clk) begin
    if (dmem_mem_rw === 1'b1) begin
      if (exp_q.size() > 0) begin
        check("mem_wr", {dmem_addr, dmem_data_w}, exp_q.pop_front());
      end else begin
        check("unexpected_wr", 64'(dmem_mem_rw), 64'd0);
      end
      mem[dmem_addr[9:0]] = dmem_data_w;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    cpu_we     = we;
    cpu_re     = re;
    cpu_addr   = a;
    cpu_data_w = d;
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  logic re_pat  [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  int   occ_exp [9] = '{1, 2, 3, 3, 4, 4, 4, 4, 4};

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    flush_req = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 1024; i++) mem[i] = 32'hD000_0000 | 32'(i);

    // Reset state
    tick();
    tick();
    #1;
    check("rst_occ",   64'(occupancy),   64'd0);
    check("rst_empty", 64'(empty),       64'd1);
    check("rst_full",  64'(full),        64'd0);
    check("rst_stall", 64'(cpu_stall),   64'd0);
    check("rst_rw",    64'(dmem_mem_rw), 64'd0);
    rst = 1'b0;
    tick();

    // T1: single store reaches memory the following cycle
    drive(1'b1, 1'b0, 32'h10, 32'h5);
    expect_wr(32'h10, 32'h5);
    #1 check("t1_no_early_wr", 64'(dmem_mem_rw), 64'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("t1_rw",    64'(dmem_mem_rw), 64'd1);
    check("t1_addr",  64'(dmem_addr),   64'h10);
    check("t1_data",  64'(dmem_data_w), 64'h5);
    tick();
    #1;
    check("t1_empty", 64'(empty),       64'd1);
    check("t1_rw_off", 64'(dmem_mem_rw), 64'd0);

    // T2: fill to DEPTH under held loads, then store while full
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b1, 32'(k), 32'h1000 + 32'(k));
      expect_wr(32'(k), 32'h1000 + 32'(k));
      tick();
      drive(1'b0, 1'b1, 32'h40, 32'h0);
      #1 check("t2_blocked", 64'(dmem_mem_rw), 64'd0);
      tick();
    end
    #1;
    check("t2_occ",      64'(occupancy),  64'd4);
    check("t2_full",     64'(full),       64'd1);
    check("t2_load_mem", 64'(cpu_data_r), 64'hD000_0040);
    cpu_addr = 32'h3;
    #1 check("t2_fwd", 64'(cpu_data_r), 64'h1003);
    drive(1'b1, 1'b0, 32'h5, 32'h1005);
    expect_wr(32'h5, 32'h1005);
    #1;
    check("t2_full_rw",   64'(dmem_mem_rw), 64'd1);
    check("t2_full_addr", 64'(dmem_addr),   64'h1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("t2_occ_kept",  64'(occupancy), 64'd4);
    check("t2_full_kept", 64'(full),      64'd1);
    repeat (4) tick();
    #1 check("t2_drained", 64'(empty), 64'd1);

    // T3: same address twice, youngest forwards (and aliasing on the low ADDR_W bits)
    drive(1'b1, 1'b1, 32'h20, 32'hAA);
`ifndef STORE_BUF_COALESCE_EN
    expect_wr(32'h20, 32'hAA);
`endif
    tick();
    drive(1'b1, 1'b1, 32'h20, 32'hBB);
    expect_wr(32'h20, 32'hBB);
    tick();
    drive(1'b0, 1'b1, 32'h20, 32'h0);
    #1;
    check("t3_fwd_young", 64'(cpu_data_r), 64'hBB);
`ifdef STORE_BUF_COALESCE_EN
    check("t3_occ", 64'(occupancy), 64'd1);
`else
    check("t3_occ", 64'(occupancy), 64'd2);
`endif
    cpu_addr = 32'h420;
    #1 check("t3_fwd_alias", 64'(cpu_data_r), 64'hBB);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) tick();
    #1 check("t3_empty", 64'(empty), 64'd1);
    drive(1'b0, 1'b1, 32'h20, 32'h0);
    #1 check("t3_mem_rd", 64'(cpu_data_r), 64'hBB);
    tick();

    // T4: flush with a competing load; stall ignores a store
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 32'h30 + 32'(k), 32'h2000 + 32'(k));
      expect_wr(32'h30 + 32'(k), 32'h2000 + 32'(k));
      tick();
    end
    flush_req = 1'b1;
    drive(1'b0, 1'b1, 32'h40, 32'h0);
    #1;
    check("t4_stall0", 64'(cpu_stall),   64'd1);
    check("t4_rw0",    64'(dmem_mem_rw), 64'd1);
    check("t4_addr0",  64'(dmem_addr),   64'h30);
    tick();
    drive(1'b1, 1'b0, 32'h99, 32'hDEAD);
    #1;
    check("t4_stall1", 64'(cpu_stall), 64'd1);
    check("t4_addr1",  64'(dmem_addr), 64'h31);
    tick();
    drive(1'b0, 1'b1, 32'h40, 32'h0);
    #1;
    check("t4_stall2", 64'(cpu_stall), 64'd1);
    check("t4_addr2",  64'(dmem_addr), 64'h32);
    tick();
    #1;
    check("t4_stall_off", 64'(cpu_stall),   64'd0);
    check("t4_empty",     64'(empty),       64'd1);
    check("t4_rw_off",    64'(dmem_mem_rw), 64'd0);
    flush_req = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // T5: reset discards pending stores
    drive(1'b1, 1'b1, 32'h50, 32'h3000);
    tick();
    drive(1'b1, 1'b1, 32'h51, 32'h3001);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("t5_pre_occ", 64'(occupancy),   64'd2);
    check("t5_rst_rw",  64'(dmem_mem_rw), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("t5_occ",   64'(occupancy), 64'd0);
    check("t5_empty", 64'(empty),     64'd1);
    repeat (3) tick();
    drive(1'b0, 1'b1, 32'h50, 32'h0);
    #1 check("t5_rd50", 64'(cpu_data_r), 64'hD000_0050);
    cpu_addr = 32'h51;
    #1 check("t5_rd51", 64'(cpu_data_r), 64'hD000_0051);
    tick();

    // T6: wrap-around with interleaved blocking loads
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, re_pat[k], 32'h60 + 32'(k), 32'h4000 + 32'(k));
      expect_wr(32'h60 + 32'(k), 32'h4000 + 32'(k));
      tick();
      drive(1'b0, 1'b1, 32'h40, 32'h0);
      #1;
      check("t6_occ",  64'(occupancy), 64'(occ_exp[k]));
      check("t6_full", 64'(full),      64'(occ_exp[k] == 4));
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (5) tick();
    #1 check("t6_empty", 64'(empty), 64'd1);
    for (int k = 0; k < 9; k += 4) begin
      drive(1'b0, 1'b1, 32'h60 + 32'(k), 32'h0);
      #1 check("t6_mem", 64'(cpu_data_r), 64'h4000 + 64'(k));
      tick();
    end

    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
